fill_fifo_burst_reader: RTL and testbench

FILL_FIFO_BURST_READER -- requirements
Module: fill_fifo_burst_reader

---
 rtl/hdmi_out_pkg.sv | 6 +
 rtl/fill_fifo_burst_reader.sv | 98 +++++++++
 tb/tb_fill_fifo_burst_reader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_out_pkg.sv
// hdmi_out_pkg: shared state encodings and default burst geometry for the line FIFO filler
package hdmi_out_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DATA, ST_CMPLT} fill_state_t;
    localparam int DEF_BURST_WORDS = 64;
    localparam int DEF_WORD_BYTES  = 4;
endpackage

// File: rtl/fill_fifo_burst_reader.sv
// fill_fifo_burst_reader: issues fixed-length master read bursts and streams the returned words into the line FIFO
module fill_fifo_burst_reader
    import hdmi_out_pkg::*;
#(
    parameter int BURST_WORDS = DEF_BURST_WORDS,
    parameter int WORD_BYTES  = DEF_WORD_BYTES
) (
    input  logic        Bus2IP_Clk,
    input  logic        Bus2IP_Resetn,
    input  logic        go_fill_fifo,
    input  logic [31:0] ddr_addr_to_read,
    input  logic        clr_status,
    output logic        ip2bus_mstrd_req,
    output logic [31:0] ip2bus_mst_addr,
    output logic [11:0] ip2bus_mst_length,
    input  logic        bus2ip_mst_cmdack,
    input  logic        bus2ip_mst_cmplt,
    input  logic        bus2ip_mst_error,
    input  logic [31:0] bus2ip_mstrd_d,
    input  logic        bus2ip_mstrd_src_rdy_n,
    input  logic        bus2ip_mstrd_eof_n,
    output logic        ip2bus_mstrd_dst_rdy_n,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_wr_data,
    input  logic        fifo_full,
    output logic        busy,
    output logic        overrun,
    output logic        err
);
    localparam logic [11:0] LEN  = 12'(BURST_WORDS * WORD_BYTES);
    localparam logic [6:0]  LAST = 7'(BURST_WORDS - 1);

    fill_state_t r_state, w_next;
    logic [31:0] r_addr, r_pend_addr;
    logic [6:0]  r_cnt;
    logic        r_pend, r_overrun, r_err;
    logic        w_beat, w_last_cnt, w_eof, w_abort, w_done, w_cmplt_exit;
    logic        w_take_pend, w_go_direct, w_go_queue, w_pend_free, w_unused;

    assign w_unused     = ^ddr_addr_to_read[1:0];
    assign w_beat       = (r_state == ST_DATA) && !fifo_full && !bus2ip_mstrd_src_rdy_n;
    assign w_last_cnt   = r_cnt == LAST;
    assign w_eof        = !bus2ip_mstrd_eof_n;
    assign w_abort      = (r_state == ST_REQ || r_state == ST_DATA) && bus2ip_mst_cmplt && bus2ip_mst_error;
    assign w_done       = w_beat && (w_eof || w_last_cnt);
    assign w_cmplt_exit = (r_state == ST_CMPLT) && bus2ip_mst_cmplt;
    assign w_take_pend  = r_pend && (r_state == ST_IDLE || w_cmplt_exit);
    assign w_go_direct  = go_fill_fifo && (r_state == ST_IDLE) && !r_pend;
    assign w_go_queue   = go_fill_fifo && !w_go_direct;
    assign w_pend_free  = !r_pend || w_take_pend;

    assign ip2bus_mstrd_req       = r_state == ST_REQ;
    assign ip2bus_mst_addr        = r_addr;
    assign ip2bus_mst_length      = LEN;
    assign ip2bus_mstrd_dst_rdy_n = !((r_state == ST_DATA) && !fifo_full);
    assign fifo_wr_en             = w_beat;
    assign fifo_wr_data           = bus2ip_mstrd_d;
    assign busy                   = r_state != ST_IDLE;
    assign overrun                = r_overrun;
    assign err                    = r_err;

    // next-state decode; an aborted burst always passes through IDLE, which then services any pending request
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = (r_pend || go_fill_fifo) ? ST_REQ : ST_IDLE;
            ST_REQ:   w_next = w_abort ? ST_IDLE : bus2ip_mst_cmdack ? ST_DATA : ST_REQ;
            ST_DATA:  w_next = w_abort ? ST_IDLE : w_done ? ST_CMPLT : ST_DATA;
            default:  w_next = !bus2ip_mst_cmplt ? ST_CMPLT : r_pend ? ST_REQ : ST_IDLE;
        endcase
    end

    // state, command address, one-deep pending slot, beat counter and sticky status
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_pend_addr <= '0;
            r_pend      <= 1'b0;
            r_cnt       <= '0;
            r_overrun   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_take_pend)
                r_addr <= r_pend_addr;
            else if (w_go_direct)
                r_addr <= {ddr_addr_to_read[31:2], 2'b00};
            if (w_go_queue && w_pend_free)
                r_pend_addr <= {ddr_addr_to_read[31:2], 2'b00};
            r_pend    <= (w_go_queue && w_pend_free) ? 1'b1 : w_take_pend ? 1'b0 : r_pend;
            r_cnt     <= (r_state != ST_DATA && w_next == ST_DATA) ? 7'd0 : w_beat ? r_cnt + 7'd1 : r_cnt;
            r_overrun <= (w_go_queue && !w_pend_free) ? 1'b1 : clr_status ? 1'b0 : r_overrun;
            r_err     <= (w_abort || (w_beat && (w_eof != w_last_cnt)) || (w_cmplt_exit && bus2ip_mst_error))
                         ? 1'b1 : clr_status ? 1'b0 : r_err;
        end
    end
endmodule

// File: tb/tb_fill_fifo_burst_reader.sv
// tb_fill_fifo_burst_reader: directed checks of burst issue, streaming, stalls, errors, pending requests and reset
module tb_fill_fifo_burst_reader;
    logic        Bus2IP_Clk = 1'b0;
    logic        Bus2IP_Resetn;
    logic        go_fill_fifo;
    logic [31:0] ddr_addr_to_read;
    logic        clr_status;
    logic        ip2bus_mstrd_req;
    logic [31:0] ip2bus_mst_addr;
    logic [11:0] ip2bus_mst_length;
    logic        bus2ip_mst_cmdack, bus2ip_mst_cmplt, bus2ip_mst_error;
    logic [31:0] bus2ip_mstrd_d;
    logic        bus2ip_mstrd_src_rdy_n, bus2ip_mstrd_eof_n, ip2bus_mstrd_dst_rdy_n;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic        fifo_full;
    logic        busy, overrun, err;

    int checks = 0;
    int errors = 0;
    logic [31:0] wq[$];

    localparam logic [31:0] A2 = 32'h2000_0106;
    localparam logic [31:0] A3 = 32'h3000_0000;

    fill_fifo_burst_reader dut (
        .Bus2IP_Clk(Bus2IP_Clk), .Bus2IP_Resetn(Bus2IP_Resetn),
        .go_fill_fifo(go_fill_fifo), .ddr_addr_to_read(ddr_addr_to_read), .clr_status(clr_status),
        .ip2bus_mstrd_req(ip2bus_mstrd_req), .ip2bus_mst_addr(ip2bus_mst_addr), .ip2bus_mst_length(ip2bus_mst_length),
        .bus2ip_mst_cmdack(bus2ip_mst_cmdack), .bus2ip_mst_cmplt(bus2ip_mst_cmplt), .bus2ip_mst_error(bus2ip_mst_error),
        .bus2ip_mstrd_d(bus2ip_mstrd_d), .bus2ip_mstrd_src_rdy_n(bus2ip_mstrd_src_rdy_n),
        .bus2ip_mstrd_eof_n(bus2ip_mstrd_eof_n), .ip2bus_mstrd_dst_rdy_n(ip2bus_mstrd_dst_rdy_n),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
        .busy(busy), .overrun(overrun), .err(err)
    );

    always #5 Bus2IP_Clk = ~Bus2IP_Clk;

    // record every FIFO write as it happens
    always @(posedge Bus2IP_Clk) if (fifo_wr_en) wq.push_back(fifo_wr_data);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Bus2IP_Clk);
        #1;
    endtask

    task automatic start(input logic [31:0] a);
        go_fill_fifo = 1'b1;
        ddr_addr_to_read = a;
        tick;
        go_fill_fifo = 1'b0;
        check("req_after_go", ip2bus_mstrd_req, 1);
        check("cmd_addr", ip2bus_mst_addr, {a[31:2], 2'b00});
        check("busy_req", busy, 1);
    endtask

    task automatic ack;
        bus2ip_mst_cmdack = 1'b1;
        tick;
        bus2ip_mst_cmdack = 1'b0;
        check("req_drop", ip2bus_mstrd_req, 0);
    endtask

    task automatic finish_idle;
        bus2ip_mst_cmplt = 1'b1;
        tick;
        bus2ip_mst_cmplt = 1'b0;
        check("idle_after_cmplt", busy, 0);
    endtask

    task automatic check_data(input logic [31:0] base);
        int bad = -1;
        for (int i = 0; i < wq.size(); i++)
            if (bad < 0 && wq[i] !== base + 32'(i)) bad = i;
        check("data_order", bad, -1);
    endtask

    task automatic burst(input int n, input int eof_at, input logic [31:0] base,
                         input int full_at, input int full_len, input int go_at);
        int k = 0;
        int fc = 0;
        int cyc = 0;
        while (k < n && cyc < 400) begin
            bus2ip_mstrd_src_rdy_n = 1'b0;
            bus2ip_mstrd_d = base + 32'(k);
            bus2ip_mstrd_eof_n = (k == eof_at - 1) ? 1'b0 : 1'b1;
            fifo_full = (k == full_at && fc < full_len);
            go_fill_fifo = go_at >= 0 && (k == go_at || k == go_at + 1);
            ddr_addr_to_read = (k == go_at) ? A2 : A3;
            #1;
            if (fifo_full) begin
                fc++;
                check("stall_dst_rdy_n", ip2bus_mstrd_dst_rdy_n, 1);
                check("stall_wr_en", fifo_wr_en, 0);
            end
            tick;
            if (!fifo_full) k++;
            cyc++;
        end
        bus2ip_mstrd_src_rdy_n = 1'b1;
        bus2ip_mstrd_eof_n = 1'b1;
        fifo_full = 1'b0;
        go_fill_fifo = 1'b0;
        if (k < n) check("burst_timeout", k, n);
    endtask

    initial begin
        Bus2IP_Resetn = 1'b0;
        go_fill_fifo = 1'b0;
        ddr_addr_to_read = '0;
        clr_status = 1'b0;
        bus2ip_mst_cmdack = 1'b0;
        bus2ip_mst_cmplt = 1'b0;
        bus2ip_mst_error = 1'b0;
        bus2ip_mstrd_d = '0;
        bus2ip_mstrd_src_rdy_n = 1'b1;
        bus2ip_mstrd_eof_n = 1'b1;
        fifo_full = 1'b0;
        #1;
        check("rst_req", ip2bus_mstrd_req, 0);
        check("rst_addr", ip2bus_mst_addr, 0);
        check("rst_len", ip2bus_mst_length, 256);
        check("rst_busy", busy, 0);
        check("rst_dst_rdy_n", ip2bus_mstrd_dst_rdy_n, 1);
        check("rst_err", err, 0);
        #20 Bus2IP_Resetn = 1'b1;
        tick;

        // nominal 64-word burst from an unaligned address
        wq.delete();
        start(32'h1000_0003);
        check("cmd_len", ip2bus_mst_length, 256);
        ack;
        burst(64, 64, 32'hA000_0000, -1, 0, -1);
        check("t1_writes", wq.size(), 64);
        check_data(32'hA000_0000);
        check("t1_err", err, 0);
        check("t1_cmplt_busy", busy, 1);
        finish_idle;

        // FIFO full for 5 cycles mid-burst
        wq.delete();
        start(32'h1000_0400);
        ack;
        burst(64, 64, 32'hB000_0000, 20, 5, -1);
        check("t2_writes", wq.size(), 64);
        check_data(32'hB000_0000);
        check("t2_err", err, 0);
        finish_idle;

        // early eof on beat 10
        wq.delete();
        start(32'h1000_0800);
        ack;
        burst(10, 10, 32'hC000_0000, -1, 0, -1);
        bus2ip_mstrd_src_rdy_n = 1'b0;
        #1;
        check("t3_no_extra_wr", fifo_wr_en, 0);
        bus2ip_mstrd_src_rdy_n = 1'b1;
        check("t3_writes", wq.size(), 10);
        check("t3_in_cmplt", busy, 1);
        check("t3_err", err, 1);
        tick;
        finish_idle;
        clr_status = 1'b1;
        tick;
        clr_status = 1'b0;
        check("t3_err_clr", err, 0);

        // two requests during DATA: first pends, second overruns
        wq.delete();
        start(32'h1000_2000);
        ack;
        burst(64, 64, 32'hD000_0000, -1, 0, 5);
        check("t4_overrun", overrun, 1);
        check("t4_writes", wq.size(), 64);
        bus2ip_mst_cmplt = 1'b1;
        tick;
        bus2ip_mst_cmplt = 1'b0;
        check("t4_pend_req", ip2bus_mstrd_req, 1);
        check("t4_pend_addr", ip2bus_mst_addr, 32'h2000_0104);
        ack;
        wq.delete();
        burst(64, 64, 32'hE000_0000, -1, 0, -1);
        check("t4b_writes", wq.size(), 64);
        check("t4b_err", err, 0);
        finish_idle;
        clr_status = 1'b1;
        tick;
        clr_status = 1'b0;
        check("t4_overrun_clr", overrun, 0);

        // reset at beat 30
        wq.delete();
        start(32'h1000_4000);
        ack;
        burst(30, 0, 32'hF000_0000, -1, 0, -1);
        bus2ip_mstrd_src_rdy_n = 1'b0;
        #1;
        check("t5_wr_before_rst", fifo_wr_en, 1);
        #1 Bus2IP_Resetn = 1'b0;
        #1;
        check("t5_rst_wr_en", fifo_wr_en, 0);
        check("t5_rst_dst_rdy_n", ip2bus_mstrd_dst_rdy_n, 1);
        check("t5_rst_req", ip2bus_mstrd_req, 0);
        check("t5_rst_addr", ip2bus_mst_addr, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_writes", wq.size(), 30);
        tick;
        check("t5_held_no_wr", wq.size(), 30);
        bus2ip_mstrd_src_rdy_n = 1'b1;
        @(negedge Bus2IP_Clk);
        Bus2IP_Resetn = 1'b1;
        tick;
        check("t5_idle", busy, 0);
        start(32'h1000_8000);
        ack;
        wq.delete();
        burst(64, 64, 32'h5000_0000, -1, 0, -1);
        check("t5b_writes", wq.size(), 64);
        check_data(32'h5000_0000);
        check("t5b_err", err, 0);
        finish_idle;

        // cmplt with error while in REQ
        wq.delete();
        start(32'h1000_C000);
        bus2ip_mst_cmplt = 1'b1;
        bus2ip_mst_error = 1'b1;
        tick;
        bus2ip_mst_cmplt = 1'b0;
        bus2ip_mst_error = 1'b0;
        check("t6_err", err, 1);
        check("t6_idle", busy, 0);
        check("t6_req", ip2bus_mstrd_req, 0);
        tick;
        check("t6_still_idle", busy, 0);
        check("t6_writes", wq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
